// File: rtl/depthwise_window_streamer.sv
// rtl/depthwise_window_streamer.sv - KxK per-channel sliding-window generator for depthwise convolution
//
// Accepts a raster-order, channel-interleaved pixel stream and emits one KxK
// window per channel for every valid output position (stride 1, no padding).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   clear                   synchronous frame resync (wins over in_valid)
//   in_valid/in_ready/in_data    pixel input handshake
//   out_valid/out_ready     window output handshake
//   out_window              window, element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_channel             channel of out_window
//   out_last                final window of the frame
module depthwise_window_streamer #(
    parameter int DATA_WIDTH     = 8,
    parameter int KERNEL_SIZE    = 3,
    parameter int IMG_WIDTH      = 8,
    parameter int IMG_HEIGHT     = 8,
    parameter int INPUT_CHANNELS = 3,
    localparam int CH_W = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clear,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_WIDTH-1:0]                     in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_window,
    output logic [CH_W-1:0]                           out_channel,
    output logic                                      out_last
);

    localparam int K     = KERNEL_SIZE;
    localparam int W     = IMG_WIDTH;
    localparam int H     = IMG_HEIGHT;
    localparam int C     = INPUT_CHANNELS;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;

    localparam logic [CH_W-1:0]  CH_LAST       = CH_W'(C - 1);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(W - 1);
    localparam logic [COL_W-1:0] COL_FIRST_OUT = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(H - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(K - 2);

    typedef enum logic {
        S_FILL   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t state, state_next;

    logic [CH_W-1:0]  chan_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;

    logic accept;
    logic emit;
    logic frame_end;

    // Storage is deliberately unreset: windows are only emitted once the
    // counters guarantee every contributing entry was written this frame.
    logic [DATA_WIDTH-1:0] line_buf [C][K-1][W];
    logic [DATA_WIDTH-1:0] win_reg  [C][K][K];
    logic [DATA_WIDTH-1:0] new_win  [K][K];
    logic [K*K*DATA_WIDTH-1:0] new_win_flat;

    assign frame_end = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST) && (chan_cnt == CH_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = S_FILL;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept && (row_cnt == ROW_FILL_LAST) && (col_cnt == COL_LAST) &&
                        (chan_cnt == CH_LAST)) begin
                        state_next = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (accept && frame_end) begin
                        state_next = S_FILL;
                    end
                end
                default: state_next = S_FILL;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready && !clear;
        emit     = accept && (state == S_STREAM) && (col_cnt >= COL_FIRST_OUT);
    end

    // Raster counters: channel fastest, then column, then row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else if (clear) begin
            chan_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else if (accept) begin
            if (chan_cnt == CH_LAST) begin
                chan_cnt <= '0;
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end else begin
                chan_cnt <= chan_cnt + 1'b1;
            end
        end
    end

    // Window after this accept: shift left, new right column is the
    // buffered column (oldest row on top) with the incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                new_win[r][c] = win_reg[chan_cnt][r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            new_win[r][K-1] = line_buf[chan_cnt][r][col_cnt];
        end
        new_win[K-1][K-1] = in_data;
    end

    always_comb begin
        new_win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                new_win_flat[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = new_win[r][c];
            end
        end
    end

    // Line buffer column rolls up by one row; window registers take new_win.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K - 2; r++) begin
                line_buf[chan_cnt][r][col_cnt] <= line_buf[chan_cnt][r+1][col_cnt];
            end
            line_buf[chan_cnt][K-2][col_cnt] <= in_data;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_reg[chan_cnt][r][c] <= new_win[r][c];
                end
            end
        end
    end

    // Output register: a new window may load in the same cycle the old one drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_window  <= '0;
            out_channel <= '0;
            out_last    <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (emit) begin
            out_valid   <= 1'b1;
            out_window  <= new_win_flat;
            out_channel <= chan_cnt;
            out_last    <= frame_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_depthwise_window_streamer.sv
// tb/tb_depthwise_window_streamer.sv - randomized scoreboard bench for depthwise_window_streamer
module tb_depthwise_window_streamer;

    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int C    = 2;
    localparam int WINW = K * K * DW;
    localparam int CHW  = (C > 1) ? $clog2(C) : 1;
    localparam int NPIX = H * W * C;
    localparam int NWIN = (H - K + 1) * (W - K + 1) * C;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [WINW-1:0] out_window;
    logic [CHW-1:0]  out_channel;
    logic            out_last;

    always #5 clk = ~clk;

    depthwise_window_streamer #(
        .DATA_WIDTH    (DW),
        .KERNEL_SIZE   (K),
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .INPUT_CHANNELS(C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_channel(out_channel),
        .out_last   (out_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [WINW-1:0] win;
        int              ch;
        bit              last;
    } exp_t;

    exp_t            exp_q[$];
    int              pix [H][W][C];
    int              mr, mc, mch;
    int              win_count, last_count;
    bit              got_first;
    logic [WINW-1:0] first_win;
    bit              hold_pending;
    logic [WINW-1:0] hold_win;

    task automatic model_reset();
        exp_q.delete();
        mr = 0;
        mc = 0;
        mch = 0;
        hold_pending = 0;
    endtask

    // Frame image is stored per position; a window is simply the KxK block
    // ending at the current pixel once it lies fully inside the frame.
    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        pix[mr][mc][mch] = int'(d);
        if (mr >= K - 1 && mc >= K - 1) begin
            e.win = '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    e.win[(i*K+j)*DW +: DW] = DW'(pix[mr-K+1+i][mc-K+1+j][mch]);
            e.ch   = mch;
            e.last = (mr == H - 1) && (mc == W - 1) && (mch == C - 1);
            exp_q.push_back(e);
        end
        mch++;
        if (mch == C) begin
            mch = 0;
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr + 1) % H;
            end
        end
    endtask

    task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit clr,
                         output bit acc);
        exp_t e;
        bit   drop;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        #2;
        if (hold_pending) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_window", out_window, hold_win);
        end
        check("valid_vs_model", out_valid, exp_q.size() != 0);
        check("in_ready", in_ready, (exp_q.size() == 0) || ordy);
        acc          = iv && in_ready && !clr;
        drop         = out_valid && ordy && !clr;
        hold_pending = out_valid && !ordy && !clr;
        hold_win     = out_window;
        if (clr) begin
            model_reset();
        end else begin
            if (drop) begin
                if (exp_q.size() == 0) begin
                    check("spurious_window", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("window", out_window, e.win);
                    check("channel", out_channel, e.ch);
                    check("last", out_last, e.last);
                    win_count++;
                    if (out_last) last_count++;
                    if (!got_first) begin
                        first_win = out_window;
                        got_first = 1;
                    end
                end
            end
            if (acc) model_accept(d);
        end
    endtask

    // mode 0: full rate, sequential data base+n; mode 1: random valid/ready/data
    task automatic feed_frame(input int base, input int mode);
        int            n = 0;
        int            guard = 0;
        bit            acc;
        bit            iv, ordy;
        logic [DW-1:0] d;
        while (n < NPIX && guard < 4000) begin
            iv   = (mode == 0) ? 1'b1 : ($urandom % 4 != 0);
            ordy = (mode == 0) ? 1'b1 : ($urandom % 3 != 0);
            d    = (mode == 0) ? DW'(base + n) : DW'($urandom);
            cycle(iv, d, ordy, 1'b0, acc);
            if (mode == 0) check("full_rate_accept", acc, 1'b1);
            if (acc) n++;
            guard++;
        end
        if (guard >= 4000) check("feed_timeout", n, NPIX);
    endtask

    task automatic drain();
        bit acc;
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic reset_counts();
        win_count  = 0;
        last_count = 0;
        got_first  = 0;
    endtask

    logic [WINW-1:0] first_exp;
    bit              acc;
    int              n;

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        reset_counts();

        // first window of a sequential frame: channel 0, positions (0..2, 0..2)
        first_exp = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                first_exp[(i*K+j)*DW +: DW] = DW'((i * W + j) * C);

        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_window", out_window, '0);
        check("reset_out_channel", out_channel, '0);
        check("reset_out_last", out_last, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-rate sequential frame
        feed_frame(0, 0);
        drain();
        check("seq_windows", win_count, NWIN);
        check("seq_lasts", last_count, 1);
        check("seq_first_window", first_win, first_exp);

        // Two frames back-to-back at full rate
        reset_counts();
        feed_frame(0, 0);
        feed_frame(100, 0);
        drain();
        check("b2b_windows", win_count, 2 * NWIN);
        check("b2b_lasts", last_count, 2);

        // Random data with random stalls, three frames back-to-back
        reset_counts();
        repeat (3) feed_frame(0, 1);
        drain();
        check("rand_windows", win_count, 3 * NWIN);
        check("rand_lasts", last_count, 3);

        // Asynchronous reset mid-frame with a window in flight
        for (int i = 0; i < 26; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        reset_counts();
        feed_frame(0, 0);
        drain();
        check("midrst_windows", win_count, NWIN);
        check("midrst_first_window", first_win, first_exp);

        // clear while a window is pending and the consumer is stalled
        n = 0;
        repeat (40) begin
            cycle(1'b1, DW'(n), 1'b0, 1'b0, acc);
            if (acc) n++;
        end
        check("stall_accepted", n, (K - 1) * W * C + (K - 1) * C + 1);
        check("stall_pending", out_valid, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        @(posedge clk);
        #1;
        check("clear_drops_window", out_valid, 1'b0);
        reset_counts();
        feed_frame(0, 0);
        drain();
        check("clear_windows", win_count, NWIN);
        check("clear_lasts", last_count, 1);
        check("clear_first_window", first_win, first_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
